// File: rtl/sonar_echo.sv
// Ultrasonic range finder: times the echo pulse after each trigger and reports the distance in cm.
// Optional build macro SONAR_FILTER_EN averages each result with the previous valid result.
`timescale 1ns/1ps

module sonar_echo #(
    parameter int CYC_PER_CM  = 2900,
    parameter int NEAR_CM     = 20,
    parameter int TIMEOUT_CYC = 900000
) (
    input  logic       clk0,
    input  logic       rst_n,
    input  logic       trig,
    input  logic       echo,
    output logic [9:0] dist_cm,
    output logic       dist_valid,
    output logic       near,
    output logic       timeout
);

    localparam int SUB_W = $clog2(CYC_PER_CM + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    state_t            state, state_nx;
    logic [2:0]        trig_sh, echo_sh;
    logic [SUB_W-1:0]  sub_cnt;
    logic [9:0]        cm_cnt, cm_next, filt_cm;
    logic [WD_W-1:0]   wd_cnt;
    logic              trig_fall, trig_rise, echo_rise, echo_fall;
    logic              sub_wrap, wd_expire;
    logic              arm, done_ok, done_to;

    // Bits [1:0] are the two synchronizer stages; bit [2] is the previous synchronized value.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            trig_sh <= '0;
            echo_sh <= '0;
        end else begin
            trig_sh <= {trig_sh[1:0], trig};
            echo_sh <= {echo_sh[1:0], echo};
        end
    end

    assign trig_fall = trig_sh[2] & ~trig_sh[1];
    assign trig_rise = ~trig_sh[2] & trig_sh[1];
    assign echo_rise = ~echo_sh[2] & echo_sh[1];
    assign echo_fall = echo_sh[2] & ~echo_sh[1];

    assign sub_wrap  = (sub_cnt == SUB_W'(CYC_PER_CM - 1));
    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    // Includes the current MEAS cycle so an echo of N*CYC_PER_CM cycles reads exactly N.
    assign cm_next   = (sub_wrap && cm_cnt != 10'd1023) ? cm_cnt + 10'd1 : cm_cnt;

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_nx = state;
        arm      = 1'b0;
        done_ok  = 1'b0;
        done_to  = 1'b0;
        case (state)
            IDLE: begin
                if (trig_fall) begin
                    state_nx = ARM;
                    arm      = 1'b1;
                end
            end
            ARM: begin
                if (wd_expire || trig_rise) begin
                    state_nx = IDLE;
                    done_to  = 1'b1;
                end else if (echo_rise) begin
                    state_nx = MEAS;
                end
            end
            MEAS: begin
                if (echo_fall) begin
                    state_nx = IDLE;
                    done_ok  = 1'b1;
                end else if (wd_expire || trig_rise) begin
                    state_nx = IDLE;
                    done_to  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            sub_cnt <= '0;
            cm_cnt  <= '0;
            wd_cnt  <= '0;
        end else if (arm) begin
            sub_cnt <= '0;
            cm_cnt  <= '0;
            wd_cnt  <= '0;
        end else if (state != IDLE) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (state == MEAS) begin
                sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
                cm_cnt  <= cm_next;
            end
        end
    end

`ifdef SONAR_FILTER_EN
    logic [9:0]  prev_cm;
    logic        prev_ok;
    logic [10:0] sum_cm;

    assign sum_cm  = {1'b0, prev_cm} + {1'b0, cm_next};
    assign filt_cm = prev_ok ? sum_cm[10:1] : cm_next;

    // A timeout breaks the averaging chain; the next good result seeds it afresh.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            prev_cm <= '0;
            prev_ok <= 1'b0;
        end else if (done_ok) begin
            prev_cm <= cm_next;
            prev_ok <= 1'b1;
        end else if (done_to) begin
            prev_ok <= 1'b0;
        end
    end
`else
    assign filt_cm = cm_next;
`endif

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            dist_cm    <= '0;
            dist_valid <= 1'b0;
            near       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            dist_valid <= done_ok | done_to;
            if (done_ok) begin
                dist_cm <= filt_cm;
                near    <= (filt_cm < 10'(NEAR_CM));
                timeout <= 1'b0;
            end else if (done_to) begin
                dist_cm <= 10'd1023;
                near    <= 1'b0;
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sonar_echo.sv
// Directed bench for sonar_echo with scaled-down timing parameters (10 cycles per cm, 3000-cycle watchdog).
`timescale 1ns/1ps

module tb_sonar_echo;

    localparam int CPC = 10;
    localparam int NCM = 20;
    localparam int TO  = 3000;

    logic       clk0 = 1'b0;
    logic       rst_n;
    logic       trig;
    logic       echo;
    logic [9:0] dist_cm;
    logic       dist_valid;
    logic       near;
    logic       timeout;

    int total = 0;
    int bad   = 0;
    int k;
    int seen_cnt;

    sonar_echo #(.CYC_PER_CM(CPC), .NEAR_CM(NCM), .TIMEOUT_CYC(TO)) dut (
        .clk0       (clk0),
        .rst_n      (rst_n),
        .trig       (trig),
        .echo       (echo),
        .dist_cm    (dist_cm),
        .dist_valid (dist_valid),
        .near       (near),
        .timeout    (timeout)
    );

    always #5 clk0 = ~clk0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk0);
    endtask

    // Returns the number of negedges until dist_valid is seen, or -1 if the budget runs out.
    task automatic wait_valid(input int budget, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < budget) begin
            @(negedge clk0);
            cyc++;
            if (dist_valid) seen = 1'b1;
        end
        if (!seen) cyc = -1;
    endtask

    task automatic ping(input int dly, input int high);
        trig = 1'b1; tick(11);
        trig = 1'b0; tick(dly);
        echo = 1'b1; tick(high);
        echo = 1'b0;
    endtask

    task automatic check_result(input string tag, input int cm, input bit nr, input bit to);
        check({tag, "_dist"},    32'(dist_cm), 32'(cm));
        check({tag, "_near"},    32'(near),    32'(nr));
        check({tag, "_timeout"}, 32'(timeout), 32'(to));
    endtask

    initial begin
        rst_n = 1'b0;
        trig  = 1'b0;
        echo  = 1'b0;
        tick(3);
        check("rst_dist",    32'(dist_cm),    32'd0);
        check("rst_valid",   32'(dist_valid), 32'd0);
        check("rst_near",    32'(near),       32'd0);
        check("rst_timeout", 32'(timeout),    32'd0);
        rst_n = 1'b1;
        tick(5);

        // 200-cycle echo = 20 cm; strobe three edges after the raw fall, one cycle wide.
        ping(20, 200);
        wait_valid(20, k);
        check("p20_latency", 32'(k), 32'd3);
        check_result("p20", 20, 1'b0, 1'b0);
        tick(1);
        check("p20_strobe_width", 32'(dist_valid), 32'd0);
        tick(10);

        // 100-cycle echo = 10 cm, below the near threshold.
        ping(20, 100);
        wait_valid(20, k);
        check("p10_latency", 32'(k), 32'd3);
`ifdef SONAR_FILTER_EN
        check_result("p10", 15, 1'b1, 1'b0);
`else
        check_result("p10", 10, 1'b1, 1'b0);
`endif
        tick(10);

        // No echo: watchdog expiry roughly TO cycles after trigger fall (plus synchronizer/register delay).
        trig = 1'b1; tick(11);
        trig = 1'b0;
        wait_valid(TO + 20, k);
        check("noecho_latency_ok", 32'(k >= TO && k <= TO + 4), 32'd1);
        check_result("noecho", 1023, 1'b0, 1'b1);
        tick(10);

        // Echo already high at trigger fall is not a rise; measurement ends in timeout.
        trig = 1'b1; echo = 1'b1; tick(11);
        trig = 1'b0; tick(100);
        echo = 1'b0;
        wait_valid(TO + 20, k);
        check("stuck_found", 32'(k > 0), 32'd1);
        check_result("stuck", 1023, 1'b0, 1'b1);
        tick(10);

        // Trigger rise while armed aborts as a timeout; its fall re-arms a normal measurement.
        trig = 1'b1; tick(11);
        trig = 1'b0; tick(20);
        trig = 1'b1;
        wait_valid(20, k);
        check("abort_latency", 32'(k), 32'd3);
        check_result("abort", 1023, 1'b0, 1'b1);
        tick(8);
        trig = 1'b0; tick(20);
        echo = 1'b1; tick(200);
        echo = 1'b0;
        wait_valid(20, k);
        check("rearm_latency", 32'(k), 32'd3);
        check_result("rearm", 20, 1'b0, 1'b0);
        tick(10);

        // Echo pulses in IDLE produce nothing.
        seen_cnt = 0;
        echo = 1'b1;
        for (int i = 0; i < 50; i++) begin tick(1); seen_cnt += int'(dist_valid); end
        echo = 1'b0;
        for (int i = 0; i < 250; i++) begin tick(1); seen_cnt += int'(dist_valid); end
        check("idle_echo_ignored", 32'(seen_cnt), 32'd0);

        // Reset during MEAS clears outputs at once and discards the measurement.
        trig = 1'b1; tick(11);
        trig = 1'b0; tick(20);
        echo = 1'b1; tick(50);
        rst_n = 1'b0;
        #1;
        check_result("midrst", 0, 1'b0, 1'b0);
        check("midrst_valid", 32'(dist_valid), 32'd0);
        tick(5);
        rst_n = 1'b1;
        tick(20);
        echo = 1'b0;
        seen_cnt = 0;
        for (int i = 0; i < 50; i++) begin tick(1); seen_cnt += int'(dist_valid); end
        check("midrst_discard", 32'(seen_cnt), 32'd0);
        ping(20, 200);
        wait_valid(20, k);
        check("postrst_latency", 32'(k), 32'd3);
        check_result("postrst", 20, 1'b0, 1'b0);
        tick(10);

        // 400-cycle echo = 40 cm raw; averaged with the previous 20 cm when filtering.
        ping(20, 400);
        wait_valid(20, k);
        check("p40_latency", 32'(k), 32'd3);
`ifdef SONAR_FILTER_EN
        check_result("p40", 30, 1'b0, 1'b0);
`else
        check_result("p40", 40, 1'b0, 1'b0);
`endif
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_time_limit observed=expired expected=finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/sonar_echo.md
SONAR_ECHO -- requirements
Module: sonar_echo

Interface
REQ-001 Parameters SHALL be: CYC_PER_CM, 2900, clk0 cycles per centimetre of range (58 us at 50 MHz).
REQ-002 NEAR_CM, 20, obstacle threshold in cm.
REQ-003 TIMEOUT_CYC, 900000, max cycles from trigger fall to echo fall.
REQ-004 Ports SHALL be: clk0  in  1  system clock, single clock domain, all flops on posedge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 trig  in  1  ultrasonic trigger from the clock divider (550-cycle high pulse, 1,000,000-cycle period).
REQ-007 echo  in  1  raw sensor echo, asynchronous to clk0.
REQ-008 dist_cm  out  10  last range in cm, registered.
REQ-009 dist_valid  out  1  one-cycle strobe on each dist_cm update.
REQ-010 near  out  1  registered: dist_cm < NEAR_CM on a valid (non-timeout) result.
REQ-011 timeout  out  1  registered: last cycle ended without a complete echo.

Function
REQ-012 trig and echo SHALL each pass a 2-flop synchronizer; edges are detected on synchronized values only.
REQ-013 FSM states SHALL be IDLE, ARM, MEAS; IDLE->ARM on trig falling edge.
REQ-014 ARM->MEAS on echo rising edge; an echo already high at trig fall SHALL not count as a rise.
REQ-015 In MEAS a sub-counter SHALL count 0..CYC_PER_CM-1 and increment a cm counter on wrap; cm counter saturates at 1023.
REQ-016 MEAS->IDLE on echo falling edge: dist_cm <= result, dist_valid=1 for one cycle, timeout<=0, near updated.
REQ-017 dist_valid SHALL assert exactly 3 clk0 edges after the raw echo falls (2 sync + 1 register).
REQ-018 A watchdog counter starting at trig fall SHALL, on reaching TIMEOUT_CYC in ARM or MEAS, force IDLE, dist_cm<=1023, near<=0, timeout<=1, dist_valid=1.
REQ-019 trig rising edge in ARM or MEAS SHALL abort as a timeout (same outputs as REQ-018).
REQ-020 Echo edges seen in IDLE SHALL be ignored; trig edges in IDLE other than falling SHALL be ignored.
REQ-021 If echo fall and watchdog expiry occur in the same cycle, echo fall SHALL win.
REQ-022 Counters SHALL clear on every IDLE->ARM transition.

Reset
REQ-023 rst_n low SHALL immediately force FSM=IDLE, all counters and synchronizers 0, dist_cm=0, dist_valid=0, near=0, timeout=0.
REQ-024 Reset mid-measurement SHALL discard the measurement; no dist_valid until a new full trig/echo cycle after release.

Configuration
REQ-025 Macro SONAR_FILTER_EN defined: dist_cm SHALL be (prev_valid_cm + new_cm) >> 1 using an 11-bit sum; prev holds the last non-timeout result, loaded with new_cm on the first result after reset or timeout; near uses the filtered value.
REQ-026 SONAR_FILTER_EN undefined: dist_cm SHALL be the raw cm count; no prev register exists; latency unchanged in both builds.

Verification
REQ-027 trig pulse, echo high 20 us later for 58000 cycles -> dist_cm=20, near=0, timeout=0, one dist_valid strobe 3 cycles after echo fall.
REQ-028 Echo high 29000 cycles -> dist_cm=10, near=1.
REQ-029 No echo after trig -> at 900000 cycles after trig fall: timeout=1, dist_cm=1023, near=0, dist_valid strobe.
REQ-030 Echo high during trig fall, stays high 10000 cycles, no new rise -> timeout result, no measurement.
REQ-031 rst_n low for 5 cycles during MEAS -> all outputs 0 immediately; next full cycle with 58000-cycle echo -> dist_cm=20.
REQ-032 SONAR_FILTER_EN: echoes of 58000 then 116000 cycles -> dist_cm 20 then 30.
